// File: rtl/mem_bus_bridge_pkg.sv
// rtl/mem_bus_bridge_pkg.sv - shared FSM encoding and default region map for mem_bus_bridge
package mem_bus_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Region 0 is the low slice: 0x108 selects chipselect[0], 0x10C chipselect[1].
   localparam logic [63:0] DEF_REGION_BASE = {32'h0000_010C, 32'h0000_0108};
   localparam logic [63:0] DEF_REGION_MASK = {32'h0000_0003, 32'h0000_0003};

   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_bus_bridge_region_decoder.sv
// rtl/mem_bus_bridge_region_decoder.sv - one-hot priority region decode of a byte address
module region_decoder #(
   parameter int N_REGIONS = 2,
   parameter int ADDR_W = 32,
   parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
   parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
   input  logic                 valid,
   input  logic [ADDR_W-1:0]    addr,
   output logic [N_REGIONS-1:0] hit
);

   // Lowest-numbered matching region wins so the output stays one-hot.
   always_comb begin
      logic found;
      hit   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REGIONS; k++) begin
         if (valid && !found &&
             ((addr & ~REGION_MASK[k*ADDR_W +: ADDR_W]) ==
              (REGION_BASE[k*ADDR_W +: ADDR_W] & ~REGION_MASK[k*ADDR_W +: ADDR_W]))) begin
            hit[k] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_bridge.sv
// rtl/mem_bus_bridge.sv - MEM-stage load/store to Avalon-MM bridge with pipeline stall and timeout
module mem_bus_bridge
   import mem_bus_bridge_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int AV_ADDR_W = 1,
   parameter int N_REGIONS = 2,
   parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
   parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   input  logic [DATA_W/8-1:0]    req_be,
   output logic [N_REGIONS-1:0]   req_hit,
   output logic                   stall,
   output logic                   rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic [N_REGIONS-1:0]   av_chipselect,
   output logic [AV_ADDR_W-1:0]   av_address,
   output logic                   av_read_n,
   output logic                   av_write_n,
   output logic [DATA_W-1:0]      av_writedata,
   output logic [DATA_W/8-1:0]    av_byteenable,
   input  logic [DATA_W-1:0]      av_readdata,
   input  logic                   av_waitrequest
);

   localparam int BE_W = DATA_W / 8;
   localparam int CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t                 state, state_nxt;
   logic                   any_hit;
   logic [ADDR_W-1:0]      sel_mask;
   logic [N_REGIONS-1:0]   region_q;
   logic                   write_q;
   logic [AV_ADDR_W-1:0]   av_addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic [BE_W-1:0]        be_q;
   logic [DATA_W-1:0]      rdata_q;
   logic                   err_q;
   logic [CNT_W-1:0]       cnt_q;

   region_decoder #(
      .N_REGIONS  (N_REGIONS),
      .ADDR_W     (ADDR_W),
      .REGION_BASE(REGION_BASE),
      .REGION_MASK(REGION_MASK)
   ) u_region_decoder (
      .valid(req_valid),
      .addr (req_addr),
      .hit  (req_hit)
   );

   assign any_hit = |req_hit;

   always_comb begin
      sel_mask = '0;
      for (int k = 0; k < N_REGIONS; k++) begin
         if (req_hit[k]) sel_mask = REGION_MASK[k*ADDR_W +: ADDR_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (any_hit) state_nxt = ST_ACCESS;
         ST_ACCESS: if (!av_waitrequest || cnt_q == CNT_MAX) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Request fields are captured once so the pipeline may present anything while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         region_q  <= '0;
         write_q   <= 1'b0;
         av_addr_q <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (any_hit) begin
                  region_q  <= req_hit;
                  write_q   <= req_write;
                  av_addr_q <= AV_ADDR_W'((req_addr & sel_mask) >> 2);
                  wdata_q   <= req_wdata;
                  be_q      <= req_be;
                  rdata_q   <= '0;
                  err_q     <= 1'b0;
                  cnt_q     <= '0;
               end
            end
            ST_ACCESS: begin
               if (!av_waitrequest) begin
                  rdata_q <= write_q ? '0 : av_readdata;
               end else if (cnt_q == CNT_MAX) begin
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stall         = 1'b0;
      rsp_valid     = 1'b0;
      rsp_rdata     = '0;
      rsp_err       = 1'b0;
      av_chipselect = '0;
      av_read_n     = 1'b1;
      av_write_n    = 1'b1;
      unique case (state)
         ST_IDLE:   stall = any_hit && !rst;
         ST_ACCESS: begin
            stall         = 1'b1;
            av_chipselect = region_q;
            av_read_n     = write_q;
            av_write_n    = !write_q;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
         end
         default: ;
      endcase
   end

   assign av_address    = av_addr_q;
   assign av_writedata  = wdata_q;
   assign av_byteenable = be_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb/tb_mem_bus_bridge.sv - randomized self-checking bench for mem_bus_bridge
module tb_mem_bus_bridge;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int AVW = 1;
   localparam int NR  = 2;
   localparam int TO  = 4;
   localparam logic [31:0] BASE_A [2] = '{32'h108, 32'h10C};
   localparam logic [31:0] MASK_A [2] = '{32'h3, 32'h3};

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_write;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_be;
   logic [NR-1:0]   req_hit;
   logic            stall, rsp_valid, rsp_err;
   logic [DW-1:0]   rsp_rdata;
   logic [NR-1:0]   av_chipselect;
   logic [AVW-1:0]  av_address;
   logic            av_read_n, av_write_n;
   logic [DW-1:0]   av_writedata;
   logic [DW/8-1:0] av_byteenable;
   logic [DW-1:0]   av_readdata;
   logic            av_waitrequest;

   mem_bus_bridge #(
      .DATA_W(DW), .ADDR_W(AW), .AV_ADDR_W(AVW), .N_REGIONS(NR),
      .REGION_BASE({32'h10C, 32'h108}), .REGION_MASK({32'h3, 32'h3}),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be), .req_hit(req_hit),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .av_chipselect(av_chipselect), .av_address(av_address),
      .av_read_n(av_read_n), .av_write_n(av_write_n),
      .av_writedata(av_writedata), .av_byteenable(av_byteenable),
      .av_readdata(av_readdata), .av_waitrequest(av_waitrequest)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle expectations, set by the driver, checked at the falling edge.
   bit              chk = 0;
   bit              e_av;
   logic            e_stall, e_rv, e_err, e_rn, e_wn;
   logic [DW-1:0]   e_rdata, e_wdata;
   logic [NR-1:0]   e_cs;
   logic [AVW-1:0]  e_addr;
   logic [DW/8-1:0] e_be;

   // Observation counters for literal transaction-level checks.
   int stall_cnt, rsp_cnt, cs_cycles, wn_low, req_cyc, rsp_cyc, prev_rsp_cyc;
   logic [DW-1:0] rsp_data;
   logic          rsp_e;
   logic [NR-1:0] cs_seen, hit_seen;

   function automatic logic [NR-1:0] model_hit(input logic v, input logic [AW-1:0] a);
      for (int k = 0; k < NR; k++)
         if (v && ((a & ~MASK_A[k]) == (BASE_A[k] & ~MASK_A[k]))) return NR'(1 << k);
      return '0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         check("req_hit", 64'(req_hit), 64'(model_hit(req_valid, req_addr)));
         check("stall", 64'(stall), 64'(e_stall));
         check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
         check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
         check("rsp_err", 64'(rsp_err), 64'(e_err));
         check("av_chipselect", 64'(av_chipselect), 64'(e_cs));
         check("av_read_n", 64'(av_read_n), 64'(e_rn));
         check("av_write_n", 64'(av_write_n), 64'(e_wn));
         if (e_av) begin
            check("av_address", 64'(av_address), 64'(e_addr));
            check("av_writedata", 64'(av_writedata), 64'(e_wdata));
            check("av_byteenable", 64'(av_byteenable), 64'(e_be));
         end
      end
      if (!rst) begin
         if (stall) stall_cnt++;
         if (av_chipselect != 0) cs_cycles++;
         if (!av_write_n) wn_low++;
         cs_seen  = cs_seen | av_chipselect;
         hit_seen = hit_seen | req_hit;
         if (rsp_valid) begin
            rsp_cnt++;
            prev_rsp_cyc = rsp_cyc;
            rsp_cyc  = cyc;
            rsp_data = rsp_rdata;
            rsp_e    = rsp_err;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_exp();
      chk = 1; e_av = 0;
      e_stall = 0; e_rv = 0; e_rdata = '0; e_err = 0;
      e_cs = '0; e_rn = 1; e_wn = 1;
   endtask

   task automatic zero_counters();
      stall_cnt = 0; rsp_cnt = 0; cs_cycles = 0; wn_low = 0;
      cs_seen = '0; hit_seen = '0;
   endtask

   function automatic logic [AW-1:0] hit_addr();
      return ($urandom_range(0, 1) == 0 ? 32'h108 : 32'h10C) + 32'($urandom_range(0, 3));
   endfunction

   function automatic logic [AW-1:0] any_addr();
      case ($urandom_range(0, 2))
         0:       return hit_addr();
         1:       return 32'h200 + 32'($urandom_range(0, 63) * 4);
         default: return $urandom;
      endcase
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         req_valid = 1'($urandom); req_write = 1'($urandom);
         req_addr = 32'h200 + 32'($urandom_range(0, 63) * 4);
         av_waitrequest = 1'($urandom); av_readdata = $urandom;
         set_idle_exp();
      end
   endtask

   // One request as seen by the bridge: nwait waitrequest cycles before the slave answers.
   task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] be, input int nwait, input logic [DW-1:0] rd,
                         input int rst_at, input bit noise);
      logic [NR-1:0]  h;
      logic [AVW-1:0] ea;
      int k, acc_len;
      bit err;
      step();
      req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
      av_waitrequest = 1'($urandom); av_readdata = $urandom;
      h = model_hit(1'b1, a);
      set_idle_exp();
      e_stall = (h != 0);
      req_cyc = cyc;
      if (h == 0) return;
      k = (h == 2'b10) ? 1 : 0;
      err = nwait > TO;
      acc_len = 1 + (err ? TO : nwait);
      ea = AVW'((a & MASK_A[k]) >> 2);
      for (int i = 0; i < acc_len; i++) begin
         step();
         if (noise) begin
            req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = any_addr();
            req_wdata = $urandom; req_be = 4'($urandom);
         end
         av_waitrequest = (i < nwait);
         av_readdata = (i == acc_len - 1 && !err) ? rd : $urandom;
         chk = 1; e_av = 1;
         e_stall = 1; e_rv = 0; e_rdata = '0; e_err = 0;
         e_cs = h; e_rn = w; e_wn = !w;
         e_addr = ea; e_wdata = wd; e_be = be;
         if (i == rst_at) begin
            rst = 1; chk = 0;
            step();
            rst = 0; req_valid = 0;
            set_idle_exp();
            return;
         end
      end
      step();
      req_valid = 1; req_write = 1'($urandom); req_addr = hit_addr();
      av_waitrequest = 1'($urandom); av_readdata = $urandom;
      set_idle_exp();
      e_rv = 1; e_rdata = (w || err) ? '0 : rd; e_err = err;
   endtask

   initial begin
      rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_be = '0;
      av_readdata = '0; av_waitrequest = 0;
      zero_counters(); rsp_cyc = 0; prev_rsp_cyc = 0; rsp_data = '0; rsp_e = 0;
      repeat (3) step();
      rst = 0;
      set_idle_exp();
      idle(2);

      // Load 0x108, no wait
      zero_counters();
      do_txn(0, 32'h108, 32'h0, 4'hF, 0, 32'h41, -1, 0);
      idle(2);
      check("l41_latency", 64'(rsp_cyc - req_cyc), 64'd2);
      check("l41_rdata", 64'(rsp_data), 64'h41);
      check("l41_err", 64'(rsp_e), 64'd0);
      check("l41_cs", 64'(cs_seen), 64'b01);
      check("l41_cs_cycles", 64'(cs_cycles), 64'd1);
      check("l41_rsp_cnt", 64'(rsp_cnt), 64'd1);

      // Store 0x10C with three wait cycles
      zero_counters();
      do_txn(1, 32'h10C, 32'h55, 4'hF, 3, 32'h0, -1, 1);
      idle(2);
      check("s55_cs", 64'(cs_seen), 64'b10);
      check("s55_wn_low", 64'(wn_low), 64'd4);
      check("s55_stall_cycles", 64'(stall_cnt), 64'd5);
      check("s55_rsp_cnt", 64'(rsp_cnt), 64'd1);
      check("s55_rdata", 64'(rsp_data), 64'd0);

      // Miss
      zero_counters();
      do_txn(0, 32'h200, 32'h0, 4'hF, 0, 32'h0, -1, 0);
      req_valid = 0;
      idle(3);
      check("miss_hit", 64'(hit_seen), 64'd0);
      check("miss_stall", 64'(stall_cnt), 64'd0);
      check("miss_cs", 64'(cs_cycles), 64'd0);
      check("miss_rsp", 64'(rsp_cnt), 64'd0);

      // Timeout
      zero_counters();
      do_txn(0, 32'h108, 32'h0, 4'hF, 50, 32'h77, -1, 0);
      idle(2);
      check("to_latency", 64'(rsp_cyc - req_cyc), 64'd6);
      check("to_err", 64'(rsp_e), 64'd1);
      check("to_rdata", 64'(rsp_data), 64'd0);

      // Reset in the second ACCESS cycle
      zero_counters();
      do_txn(0, 32'h10C, 32'h0, 4'hF, 3, 32'h99, 1, 0);
      idle(4);
      check("rst_rsp", 64'(rsp_cnt), 64'd0);

      // Back-to-back loads
      zero_counters();
      do_txn(0, 32'h108, 32'h0, 4'hF, 0, 32'hA1, -1, 0);
      do_txn(0, 32'h10C, 32'h0, 4'hF, 0, 32'hB2, -1, 0);
      idle(2);
      check("b2b_rsp_cnt", 64'(rsp_cnt), 64'd2);
      check("b2b_spacing", 64'(rsp_cyc - prev_rsp_cyc), 64'd3);
      check("b2b_rdata", 64'(rsp_data), 64'hB2);
      check("b2b_cs", 64'(cs_seen), 64'b11);

      for (int t = 0; t < 80; t++) begin
         do_txn(1'($urandom), any_addr(), $urandom, 4'($urandom),
                $urandom_range(0, 6), $urandom,
                ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1)) : -1, 1);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      idle(2);
      chk = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
